// File: rtl/imm_ext_arbiter.sv
// Two-port arbiter in front of the shared 16-bit immediate extend unit.
// Registers the winning request into the unit, returns the tagged result, counts completions.
module imm_ext_arbiter #(
  parameter int PRIO_MODE = 0,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [8:0]       req0_imm,
  input  logic [1:0]       req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [8:0]       req1_imm,
  input  logic [1:0]       req1_sel,
  output logic [8:0]       ext_imm,
  output logic [1:0]       ext_sel,
  input  logic [15:0]      ext_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [15:0]      rsp_data,
  output logic             rsp_id,
  output logic [CNT_W-1:0] srv0_cnt,
  output logic [CNT_W-1:0] srv1_cnt
);

  // state | meaning
  // IDLE  | waiting for a request, readies follow the grant
  // EXT   | extend unit settling on ext_imm/ext_sel
  // RESP  | response held until rsp_ready
  typedef enum logic [1:0] {IDLE = 2'd0, EXT = 2'd1, RESP = 2'd2} state_t;

  state_t state, state_nxt;
  logic   last_grant;
  logic   id_q;
  logic   grant1;
  logic   any_valid;
  logic   accept;
  logic   rsp_done;

  // grant1 is only ever high when req1_valid is high
  always_comb begin
    any_valid = req0_valid | req1_valid;
    if (req0_valid && req1_valid)
      grant1 = (PRIO_MODE == 0) ? ~last_grant : 1'b0;
    else
      grant1 = req1_valid;
  end

  assign accept   = (state == IDLE) && any_valid;
  assign rsp_done = (state == RESP) && rsp_valid && rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = EXT;
      EXT:     state_nxt = RESP;
      RESP:    if (rsp_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (state == IDLE) begin
      req0_ready = any_valid & ~grant1;
      req1_ready = grant1;
    end
  end

  // last_grant resets to 1 so req0 wins the first tie
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_imm    <= '0;
      ext_sel    <= '0;
      id_q       <= 1'b0;
      last_grant <= 1'b1;
    end else if (accept) begin
      ext_imm    <= grant1 ? req1_imm : req0_imm;
      ext_sel    <= grant1 ? req1_sel : req0_sel;
      id_q       <= grant1;
      last_grant <= grant1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= 1'b0;
    end else if (state == EXT) begin
      rsp_valid <= 1'b1;
      rsp_data  <= ext_out;
      rsp_id    <= id_q;
    end else if (rsp_done) begin
      rsp_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      srv0_cnt <= '0;
      srv1_cnt <= '0;
    end else if (rsp_done) begin
      if (!rsp_id && (srv0_cnt != {CNT_W{1'b1}})) srv0_cnt <= srv0_cnt + CNT_W'(1);
      if (rsp_id && (srv1_cnt != {CNT_W{1'b1}}))  srv1_cnt <= srv1_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_ext_arbiter.sv
// Directed bench: dut_a is round-robin with 8-bit counters, dut_b is fixed priority with 2-bit counters.
module tb_imm_ext_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0;
  logic [8:0]  req0_imm = '0;
  logic [1:0]  req0_sel = '0;
  logic        req1_valid = 1'b0;
  logic [8:0]  req1_imm = '0;
  logic [1:0]  req1_sel = '0;
  logic        rsp_ready = 1'b0;

  logic        a_req0_ready, a_req1_ready, a_rsp_valid, a_rsp_id;
  logic [8:0]  a_ext_imm;
  logic [1:0]  a_ext_sel;
  logic [15:0] a_ext_out, a_rsp_data;
  logic [7:0]  a_srv0, a_srv1;

  logic        b_req0_ready, b_req1_ready, b_rsp_valid, b_rsp_id;
  logic [8:0]  b_ext_imm;
  logic [1:0]  b_ext_sel;
  logic [15:0] b_ext_out, b_rsp_data;
  logic [1:0]  b_srv0, b_srv1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // stand-in for the combinational extend unit
  function automatic logic [15:0] ext_fn(input logic [8:0] imm, input logic [1:0] sel);
    case (sel)
      2'b00:   return {{7{imm[8]}}, imm};
      2'b01:   return {{8{imm[7]}}, imm[7:0]};
      2'b10:   return {{10{imm[5]}}, imm[5:0]};
      default: return {7'b0, imm};
    endcase
  endfunction

  assign a_ext_out = ext_fn(a_ext_imm, a_ext_sel);
  assign b_ext_out = ext_fn(b_ext_imm, b_ext_sel);

  imm_ext_arbiter #(.PRIO_MODE(0), .CNT_W(8)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(a_req0_ready), .req0_imm(req0_imm), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(a_req1_ready), .req1_imm(req1_imm), .req1_sel(req1_sel),
    .ext_imm(a_ext_imm), .ext_sel(a_ext_sel), .ext_out(a_ext_out),
    .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(a_rsp_data), .rsp_id(a_rsp_id),
    .srv0_cnt(a_srv0), .srv1_cnt(a_srv1)
  );

  imm_ext_arbiter #(.PRIO_MODE(1), .CNT_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(b_req0_ready), .req0_imm(req0_imm), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(b_req1_ready), .req1_imm(req1_imm), .req1_sel(req1_sel),
    .ext_imm(b_ext_imm), .ext_sel(b_ext_sel), .ext_out(b_ext_out),
    .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready), .rsp_data(b_rsp_data), .rsp_id(b_rsp_id),
    .srv0_cnt(b_srv0), .srv1_cnt(b_srv1)
  );

  task automatic pulse_reset();
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    rst_n      = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_chk++;
    if ({a_req0_ready, a_req1_ready, a_rsp_valid} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 000", {a_req0_ready, a_req1_ready, a_rsp_valid});
    end
    n_chk++;
    if ({a_ext_imm, a_ext_sel, a_rsp_data, a_rsp_id, a_srv0, a_srv1} !== '0) begin
      n_fail++; $display("FAIL reset_regs: ext_imm=%h ext_sel=%h data=%h id=%b srv0=%0d srv1=%0d",
                         a_ext_imm, a_ext_sel, a_rsp_data, a_rsp_id, a_srv0, a_srv1);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_req0_single();
    pulse_reset();
    req0_imm = 9'h100; req0_sel = 2'b00; req0_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    n_chk++;
    if ({a_req0_ready, a_req1_ready} !== 2'b10) begin
      n_fail++; $display("FAIL req0_ready: got %b want 10", {a_req0_ready, a_req1_ready});
    end
    @(negedge clk);
    req0_valid = 1'b0;
    n_chk++;
    if (a_rsp_valid !== 1'b0 || a_ext_imm !== 9'h100) begin
      n_fail++; $display("FAIL req0_ext: rsp_valid=%b ext_imm=%h want 0/100", a_rsp_valid, a_ext_imm);
    end
    @(negedge clk);
    n_chk++;
    if (a_rsp_valid !== 1'b1 || a_rsp_data !== 16'hFF00 || a_rsp_id !== 1'b0) begin
      n_fail++; $display("FAIL req0_rsp: valid=%b data=%h id=%b want 1/ff00/0", a_rsp_valid, a_rsp_data, a_rsp_id);
    end
    @(negedge clk);
    n_chk++;
    if (a_rsp_valid !== 1'b0 || a_srv0 !== 8'd1 || a_srv1 !== 8'd0) begin
      n_fail++; $display("FAIL req0_cnt: valid=%b srv0=%0d srv1=%0d want 0/1/0", a_rsp_valid, a_srv0, a_srv1);
    end
  endtask

  task automatic test_req1_seq();
    logic [8:0]  imms [3] = '{9'h080, 9'h020, 9'h1FF};
    logic [1:0]  sels [3] = '{2'b01, 2'b10, 2'b11};
    logic [15:0] exps [3] = '{16'hFF80, 16'hFFE0, 16'h01FF};
    pulse_reset();
    rsp_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req1_imm = imms[i]; req1_sel = sels[i]; req1_valid = 1'b1;
      #1;
      n_chk++;
      if ({a_req0_ready, a_req1_ready} !== 2'b01) begin
        n_fail++; $display("FAIL req1_ready[%0d]: got %b want 01", i, {a_req0_ready, a_req1_ready});
      end
      @(negedge clk);
      req1_valid = 1'b0;
      @(negedge clk);
      n_chk++;
      if (a_rsp_valid !== 1'b1 || a_rsp_data !== exps[i] || a_rsp_id !== 1'b1) begin
        n_fail++; $display("FAIL req1_rsp[%0d]: valid=%b data=%h id=%b want 1/%h/1",
                           i, a_rsp_valid, a_rsp_data, a_rsp_id, exps[i]);
      end
      @(negedge clk);
    end
    n_chk++;
    if (a_srv1 !== 8'd3 || a_srv0 !== 8'd0) begin
      n_fail++; $display("FAIL req1_cnt: srv1=%0d srv0=%0d want 3/0", a_srv1, a_srv0);
    end
  endtask

  task automatic test_round_robin();
    int n;
    logic exp_id;
    pulse_reset();
    req0_imm = 9'h100; req0_sel = 2'b00;
    req1_imm = 9'h07F; req1_sel = 2'b01;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      exp_id = k[0];
      n = 0;
      while (!(a_req0_ready || a_req1_ready) && n < 10) begin @(negedge clk); n++; end
      n_chk++;
      if ({a_req1_ready, a_req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL rr_grant[%0d]: ready1/0=%b want id %0d", k, {a_req1_ready, a_req0_ready}, exp_id);
      end
      n = 0;
      do begin @(negedge clk); n++; end while (!a_rsp_valid && n < 10);
      n_chk++;
      if (a_rsp_valid !== 1'b1 || a_rsp_id !== exp_id || a_rsp_data !== (exp_id ? 16'h007F : 16'hFF00)) begin
        n_fail++; $display("FAIL rr_rsp[%0d]: valid=%b id=%b data=%h want 1/%0d/%h",
                           k, a_rsp_valid, a_rsp_id, a_rsp_data, exp_id, exp_id ? 16'h007F : 16'hFF00);
      end
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (a_srv0 !== 8'd2 || a_srv1 !== 8'd2) begin
      n_fail++; $display("FAIL rr_cnt: srv0=%0d srv1=%0d want 2/2", a_srv0, a_srv1);
    end
  endtask

  task automatic test_fixed_prio();
    int n;
    logic r1_seen;
    r1_seen = 1'b0;
    pulse_reset();
    req0_imm = 9'h100; req0_sel = 2'b00;
    req1_imm = 9'h07F; req1_sel = 2'b01;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!(b_req0_ready || b_req1_ready) && n < 10) begin
        r1_seen |= b_req1_ready;
        @(negedge clk); n++;
      end
      r1_seen |= b_req1_ready;
      n_chk++;
      if (b_req0_ready !== 1'b1) begin
        n_fail++; $display("FAIL prio_grant[%0d]: req0_ready=%b want 1", k, b_req0_ready);
      end
      n = 0;
      do begin @(negedge clk); n++; r1_seen |= b_req1_ready; end while (!b_rsp_valid && n < 10);
      n_chk++;
      if (b_rsp_valid !== 1'b1 || b_rsp_id !== 1'b0 || b_rsp_data !== 16'hFF00) begin
        n_fail++; $display("FAIL prio_rsp[%0d]: valid=%b id=%b data=%h want 1/0/ff00", k, b_rsp_valid, b_rsp_id, b_rsp_data);
      end
    end
    n_chk++;
    if (r1_seen !== 1'b0) begin
      n_fail++; $display("FAIL prio_req1_ready: seen high=%b want 0", r1_seen);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    int n;
    pulse_reset();
    req0_imm = 9'h0AB; req0_sel = 2'b00; req0_valid = 1'b1; rsp_ready = 1'b0;
    @(negedge clk);
    req0_imm = 9'h155; req0_sel = 2'b11;
    n = 0;
    while (!a_rsp_valid && n < 10) begin @(negedge clk); n++; end
    for (int c = 0; c < 5; c++) begin
      n_chk++;
      if (a_rsp_valid !== 1'b1 || a_rsp_data !== 16'h00AB || a_rsp_id !== 1'b0 ||
          a_req0_ready !== 1'b0 || a_req1_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_hold[%0d]: valid=%b data=%h id=%b rdy=%b%b want 1/00ab/0/00",
                           c, a_rsp_valid, a_rsp_data, a_rsp_id, a_req0_ready, a_req1_ready);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    n_chk++;
    if (a_req0_ready !== 1'b0) begin
      n_fail++; $display("FAIL bp_ready_early: req0_ready=%b want 0", a_req0_ready);
    end
    @(negedge clk);
    n_chk++;
    if (a_req0_ready !== 1'b1 || a_srv0 !== 8'd1 || a_rsp_valid !== 1'b0) begin
      n_fail++; $display("FAIL bp_next: req0_ready=%b srv0=%0d valid=%b want 1/1/0", a_req0_ready, a_srv0, a_rsp_valid);
    end
    @(negedge clk);
    req0_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if (a_rsp_valid !== 1'b1 || a_rsp_data !== 16'h0155) begin
      n_fail++; $display("FAIL bp_second: valid=%b data=%h want 1/0155", a_rsp_valid, a_rsp_data);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n;
    pulse_reset();
    req0_imm = 9'h100; req0_sel = 2'b00; req0_valid = 1'b1; rsp_ready = 1'b1;
    @(negedge clk); req0_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    req0_valid = 1'b1;
    @(negedge clk);
    req0_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (a_rsp_valid !== 1'b0 || a_srv0 !== 8'd0 || a_rsp_data !== 16'h0 || a_ext_imm !== 9'h0) begin
      n_fail++; $display("FAIL mid_reset: valid=%b srv0=%0d data=%h ext_imm=%h want 0/0/0/0",
                         a_rsp_valid, a_srv0, a_rsp_data, a_ext_imm);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    n_chk++;
    if (a_rsp_valid !== 1'b0 || a_srv0 !== 8'd0) begin
      n_fail++; $display("FAIL mid_stray: valid=%b srv0=%0d want 0/0", a_rsp_valid, a_srv0);
    end
    req1_imm = 9'h01F; req1_sel = 2'b10; req1_valid = 1'b1;
    @(negedge clk);
    req1_valid = 1'b0;
    n = 0;
    while (!a_rsp_valid && n < 10) begin @(negedge clk); n++; end
    n_chk++;
    if (a_rsp_valid !== 1'b1 || a_rsp_data !== 16'h001F || a_rsp_id !== 1'b1) begin
      n_fail++; $display("FAIL mid_after: valid=%b data=%h id=%b want 1/001f/1", a_rsp_valid, a_rsp_data, a_rsp_id);
    end
    @(negedge clk);
    n_chk++;
    if (a_srv1 !== 8'd1 || a_srv0 !== 8'd0) begin
      n_fail++; $display("FAIL mid_cnt: srv1=%0d srv0=%0d want 1/0", a_srv1, a_srv0);
    end
  endtask

  task automatic test_saturation();
    int n;
    logic [1:0] exp_cnt;
    pulse_reset();
    req0_imm = 9'h001; req0_sel = 2'b00; rsp_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      exp_cnt = (k >= 2) ? 2'd3 : 2'(k + 1);
      req0_valid = 1'b1;
      @(negedge clk);
      req0_valid = 1'b0;
      n = 0;
      while (!b_rsp_valid && n < 10) begin @(negedge clk); n++; end
      @(negedge clk);
      n_chk++;
      if (b_srv0 !== exp_cnt || b_srv1 !== 2'd0) begin
        n_fail++; $display("FAIL sat[%0d]: srv0=%0d srv1=%0d want %0d/0", k, b_srv0, b_srv1, exp_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_req0_single();
    test_req1_seq();
    test_round_robin();
    test_fixed_prio();
    test_backpressure();
    test_reset_mid();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
